npu_job_sequencer: RTL and testbench

Job sequencer for the `atom_npu_core` datapath. It buffers up to DEPTH input/weight nibble pairs and, on a `run` command, issues them one at a time to the core using the core's `start`/`done` handshake. It accumulates each 4-bit core result into a saturating accumulator and reports completion or a timeout. It sits between the top-level pin wrapper and the core, so a host can stream a vector of operands and read back a single accumulated value.

---
 rtl/npu_job_sequencer.sv | 142 ++++++++++++++
 tb/tb_npu_job_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_job_sequencer.sv
// npu_job_sequencer: buffers operand pairs, issues them to atom_npu_core,
// and accumulates core results into a saturating sum.
module npu_job_sequencer #(
  parameter int DEPTH   = 8,
  parameter int ACC_W   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  input  logic [3:0]       load_data,
  input  logic [3:0]       load_weight,
  output logic             load_ready,
  input  logic             run,
  output logic             core_start,
  output logic [3:0]       core_input,
  output logic [3:0]       core_weight,
  input  logic [3:0]       core_output,
  input  logic             core_done,
  output logic [ACC_W-1:0] acc_out,
  output logic             busy,
  output logic             job_done,
  output logic             timeout_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [3:0]       buf_d [DEPTH];
  logic [3:0]       buf_w [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, rd_nx;
  logic [CW-1:0]    count;
  logic [TW-1:0]    timer;
  logic [ACC_W-1:0] acc, acc_sat;
  logic [ACC_W:0]   sum;
  logic             err;
  logic [3:0]       op_d, op_w;

  logic accept, go, last, tmo, room;

  assign room   = count < CW'(DEPTH);
  // run takes priority over a simultaneous load
  assign accept = (state == IDLE) && load_valid && room && !run;
  assign go     = (state == IDLE) && run && (count != '0);
  assign last   = {1'b0, rd_ptr} == (count - 1'b1);
  assign tmo    = timer == TW'(TIMEOUT - 1);
  assign rd_nx  = rd_ptr + 1'b1;

  assign sum     = {1'b0, acc} + (ACC_W + 1)'(core_output);
  assign acc_sat = sum[ACC_W] ? '1 : sum[ACC_W-1:0];

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (go) state_nx = ISSUE;
      ISSUE: state_nx = WAIT;
      WAIT: begin
        if (core_done)
          state_nx = last ? DONE : ISSUE;
        else if (tmo)
          state_nx = DONE;
      end
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      buf_d[wr_ptr] <= load_data;
      buf_w[wr_ptr] <= load_weight;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      timer  <= '0;
      acc    <= '0;
      err    <= 1'b0;
      op_d   <= '0;
      op_w   <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
        count  <= count + 1'b1;
      end
      if (go) begin
        acc    <= '0;
        rd_ptr <= '0;
        err    <= 1'b0;
        op_d   <= buf_d[0];
        op_w   <= buf_w[0];
      end
      if (state == ISSUE)
        timer <= '0;
      if (state == WAIT) begin
        if (core_done) begin
          acc <= acc_sat;
          if (!last) begin
            rd_ptr <= rd_nx;
            op_d   <= buf_d[rd_nx];
            op_w   <= buf_w[rd_nx];
          end
        end else if (tmo) begin
          err <= 1'b1;
        end else begin
          timer <= timer + 1'b1;
        end
      end
      if (state == DONE) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end
    end
  end

  assign load_ready  = (state == IDLE) && room;
  assign core_start  = state == ISSUE;
  assign busy        = state != IDLE;
  assign job_done    = state == DONE;
  assign core_input  = op_d;
  assign core_weight = op_w;
  assign acc_out     = acc;
  assign timeout_err = err;

endmodule

// File: tb/tb_npu_job_sequencer.sv
// tb_npu_job_sequencer: directed and random jobs against a
// queue-based reference of loads, issue order, sums and latency.
module tb_npu_job_sequencer;

  localparam int DEPTH   = 8;
  localparam int ACC_W   = 6;
  localparam int TIMEOUT = 15;
  localparam int AMAX    = (1 << ACC_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             load_valid = 1'b0;
  logic [3:0]       load_data = '0;
  logic [3:0]       load_weight = '0;
  logic             load_ready;
  logic             run = 1'b0;
  logic             core_start;
  logic [3:0]       core_input;
  logic [3:0]       core_weight;
  logic [3:0]       core_output;
  logic             core_done;
  logic [ACC_W-1:0] acc_out;
  logic             busy;
  logic             job_done;
  logic             timeout_err;

  always #5 clk = ~clk;

  npu_job_sequencer #(
    .DEPTH(DEPTH),
    .ACC_W(ACC_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .load_valid(load_valid),
    .load_data(load_data),
    .load_weight(load_weight),
    .load_ready(load_ready),
    .run(run),
    .core_start(core_start),
    .core_input(core_input),
    .core_weight(core_weight),
    .core_output(core_output),
    .core_done(core_done),
    .acc_out(acc_out),
    .busy(busy),
    .job_done(job_done),
    .timeout_err(timeout_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // core model: per-element result and latency (0 = never answers)
  int rv[DEPTH];
  int rl[DEPTH];
  int sidx;
  int cd;
  logic [3:0] co;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sidx <= 0;
      cd   <= 0;
      co   <= '0;
    end else if (core_start) begin
      co   <= 4'(rv[sidx % DEPTH]);
      cd   <= rl[sidx % DEPTH];
      sidx <= sidx + 1;
    end else begin
      if (cd > 0) cd <= cd - 1;
      if (job_done) sidx <= 0;
    end
  end

  assign core_done   = (cd == 1);
  assign core_output = co;

  logic [3:0] qd[$];
  logic [3:0] qw[$];

  task automatic load_pairs(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      load_valid  = 1'b1;
      load_data   = 4'($urandom);
      load_weight = 4'($urandom);
      @(negedge clk);
      chk("load_ready", load_ready, qd.size() < DEPTH);
      if (qd.size() < DEPTH) begin
        qd.push_back(load_data);
        qw.push_back(load_weight);
      end
    end
    @(posedge clk);
    #1 load_valid = 1'b0;
  endtask

  task automatic run_job(input bit poke);
    int n;
    int exp_acc;
    int exp_lat;
    int exp_starts;
    int starts;
    int lat;
    bit exp_err;
    n          = qd.size();
    exp_acc    = 0;
    exp_lat    = 1;
    exp_starts = 0;
    exp_err    = 1'b0;
    starts     = 0;
    lat        = -1;
    for (int i = 0; i < n; i++) begin
      exp_starts++;
      if (rl[i] == 0 || rl[i] > TIMEOUT) begin
        exp_lat += 1 + TIMEOUT;
        exp_err = 1'b1;
        break;
      end
      exp_lat += 1 + rl[i];
      exp_acc += rv[i];
      if (exp_acc > AMAX) exp_acc = AMAX;
    end
    @(posedge clk);
    #1 run = 1'b1;
    @(posedge clk);
    #1 run = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("busy_n1", busy, 1);
        chk("start_n1", core_start, 1);
      end
      if (core_start) begin
        if (starts < n) begin
          chk("op_in", core_input, qd[starts]);
          chk("op_wt", core_weight, qw[starts]);
        end
        starts++;
      end else if (busy && !job_done && starts > 0 && starts <= n) begin
        chk("op_hold", core_input, qd[starts-1]);
      end
      if (job_done) begin
        lat = c;
        break;
      end
      if (poke && c == 2) begin
        run         = 1'b1;
        load_valid  = 1'b1;
        load_data   = 4'($urandom);
        load_weight = 4'($urandom);
      end
      @(posedge clk);
      #1;
      run        = 1'b0;
      load_valid = 1'b0;
    end
    chk("latency", lat, exp_lat);
    chk("starts", starts, exp_starts);
    chk("acc", acc_out, exp_acc);
    chk("tmo_err", timeout_err, exp_err);
    @(posedge clk);
    @(negedge clk);
    chk("done_once", job_done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_ready", load_ready, 1);
    chk("acc_hold", acc_out, exp_acc);
    qd.delete();
    qw.delete();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      rv[i] = 0;
      rl[i] = 1;
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", load_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_start", core_start, 0);
    chk("rst_in", core_input, 0);
    chk("rst_wt", core_weight, 0);
    chk("rst_acc", acc_out, 0);
    chk("rst_done", job_done, 0);
    chk("rst_err", timeout_err, 0);

    // run with an empty buffer is ignored
    @(posedge clk);
    #1 run = 1'b1;
    @(posedge clk);
    #1 run = 1'b0;
    @(negedge clk);
    chk("empty_busy", busy, 0);

    // basic job: 2+5+7, two-cycle core
    load_pairs(3);
    rv[0] = 2; rv[1] = 5; rv[2] = 7;
    for (int i = 0; i < DEPTH; i++) rl[i] = 2;
    run_job(1'b0);

    // full buffer with a mid-job run/load poke
    load_pairs(9);
    for (int i = 0; i < DEPTH; i++) begin
      rv[i] = int'($urandom_range(0, 15));
      rl[i] = int'($urandom_range(1, 3));
    end
    run_job(1'b1);

    // saturation
    load_pairs(8);
    for (int i = 0; i < DEPTH; i++) begin
      rv[i] = 15;
      rl[i] = 1;
    end
    run_job(1'b0);

    // timeout on element 2, then a clean job clears the flag
    load_pairs(3);
    rv[0] = 9; rl[0] = 2;
    rv[1] = 4; rl[1] = 0;
    run_job(1'b0);
    load_pairs(2);
    rv[0] = 3; rl[0] = TIMEOUT;
    rv[1] = 6; rl[1] = 1;
    run_job(1'b0);

    // async reset during the second element's wait
    load_pairs(3);
    rv[0] = 11; rl[0] = 1;
    rv[1] = 2;  rl[1] = 3;
    @(posedge clk);
    #1 run = 1'b1;
    @(posedge clk);
    #1 run = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_acc", acc_out, 11);
    rst_n = 1'b0;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_start", core_start, 0);
    chk("ar_acc", acc_out, 0);
    chk("ar_ready", load_ready, 1);
    chk("ar_in", core_input, 0);
    chk("ar_done", job_done, 0);
    #3 rst_n = 1'b1;
    qd.delete();
    qw.delete();
    load_pairs(2);
    rv[0] = 5; rl[0] = 1;
    rv[1] = 8; rl[1] = 2;
    run_job(1'b0);

    // random jobs
    for (int j = 0; j < 20; j++) begin
      load_pairs(int'($urandom_range(1, DEPTH + 2)));
      for (int i = 0; i < DEPTH; i++) begin
        rv[i] = int'($urandom_range(0, 15));
        rl[i] = int'($urandom_range(1, 4));
        if ($urandom_range(0, 9) == 0) rl[i] = TIMEOUT;
        if ($urandom_range(0, 15) == 0) rl[i] = 0;
      end
      run_job(1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
